// File: rtl/trap_redirect_if.sv
// -----------------------------------------------------------------------------
// trap_redirect_if
//   Bundles the trap/MRET redirect sequencer's pipeline-facing signals.
//   master : the surrounding pipeline (EHU, XB decode, fetch). It drives the
//            event requests and receives the flush/stall/redirect controls.
//   slave  : the trap_redirect sequencer itself.
//   Signals
//     XB_bubble            XB stage holds a bubble (qualifies mret)
//     initiate_illinst     illegal-instruction trap request (bubble-qualified)
//     initiate_misaligned  misaligned trap request (bubble-qualified)
//     mret                 XB-stage instruction is MRET
//     csr_mepc[31:0]       current mepc from the EHU
//     flush                kill FD/XB stage contents
//     stall_fetch          hold the fetch PC
//     pc_redirect          one-cycle strobe: fetch loads pc_target
//     pc_target[31:0]      latched redirect address
//     trap_kind[1:0]       latched event type (00 none, 01 ill, 10 mis, 11 mret)
//     trap_count[15:0]     exceptions accepted since reset (MRET not counted)
// -----------------------------------------------------------------------------
interface trap_redirect_if;
  logic        XB_bubble;
  logic        initiate_illinst;
  logic        initiate_misaligned;
  logic        mret;
  logic [31:0] csr_mepc;

  logic        flush;
  logic        stall_fetch;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic [1:0]  trap_kind;
  logic [15:0] trap_count;

  modport master (
    output XB_bubble, initiate_illinst, initiate_misaligned, mret, csr_mepc,
    input  flush, stall_fetch, pc_redirect, pc_target, trap_kind, trap_count
  );

  modport slave (
    input  XB_bubble, initiate_illinst, initiate_misaligned, mret, csr_mepc,
    output flush, stall_fetch, pc_redirect, pc_target, trap_kind, trap_count
  );
endinterface

// File: rtl/trap_redirect.sv
// -----------------------------------------------------------------------------
// trap_redirect
//   Trap and MRET program-counter redirect sequencer. On an accepted event it
//   flushes FD/XB for FLUSH_CYCLES cycles (fetch stalled), then spends one
//   more flushing cycle strobing pc_redirect so fetch loads pc_target.
//   Exceptions redirect to MTVEC_BASE; MRET redirects to word-aligned mepc.
//
//   Parameters
//     MTVEC_BASE    direct-mode trap vector, must be word-aligned
//     FLUSH_CYCLES  flush cycles before the redirect, legal range 1..15
//   Ports
//     clk    single clock, rising edge
//     reset  synchronous, active-high
//     bus    trap_redirect_if.slave (event inputs, control/target outputs)
// -----------------------------------------------------------------------------
module trap_redirect #(
  parameter logic [31:0] MTVEC_BASE   = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  trap_redirect_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLUSH    = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    KIND_NONE = 2'b00,
    KIND_ILL  = 2'b01,
    KIND_MIS  = 2'b10,
    KIND_MRET = 2'b11
  } kind_t;

  // The counter counts down to zero, so the last FLUSH cycle is the one
  // that sees cnt == 0.
  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] target_q, target_d;
  kind_t       kind_q, kind_d;
  logic [15:0] count_q, count_d;

  logic        mret_ok;

  // MRET is only real when XB holds an instruction; the EHU requests
  // arrive already qualified.
  assign mret_ok = bus.mret & ~bus.XB_bubble;

  // NOTE: every variable written here gets a default first so no path
  // leaves it unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    kind_d   = kind_q;
    count_d  = count_q;

    unique case (state_q)
      S_IDLE: begin
        // Priority: illegal instruction, misaligned, then MRET. An
        // exception in the same cycle as MRET discards the MRET.
        if (bus.initiate_illinst) begin
          target_d = MTVEC_BASE;
          kind_d   = KIND_ILL;
          count_d  = count_q + 16'd1;
          cnt_d    = CNT_LOAD;
          state_d  = S_FLUSH;
        end else if (bus.initiate_misaligned) begin
          target_d = MTVEC_BASE;
          kind_d   = KIND_MIS;
          count_d  = count_q + 16'd1;
          cnt_d    = CNT_LOAD;
          state_d  = S_FLUSH;
        end else if (mret_ok) begin
          // mepc is captured here, so later CSR writes cannot disturb
          // the redirect already in flight.
          target_d = {bus.csr_mepc[31:2], 2'b00};
          kind_d   = KIND_MRET;
          cnt_d    = CNT_LOAD;
          state_d  = S_FLUSH;
        end
      end

      // Event inputs are deliberately ignored in FLUSH and REDIRECT: a
      // request still held on the first IDLE cycle counts as a new event.
      S_FLUSH: begin
        if (cnt_q == 4'd0) begin
          state_d = S_REDIRECT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_REDIRECT: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      target_q <= 32'h0000_0000;
      kind_q   <= KIND_NONE;
      count_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      kind_q   <= kind_d;
      count_q  <= count_d;
    end
  end

  // Moore controls decoded straight from the state register.
  assign bus.flush       = (state_q != S_IDLE);
  assign bus.stall_fetch = (state_q == S_FLUSH);
  assign bus.pc_redirect = (state_q == S_REDIRECT);

  assign bus.pc_target  = target_q;
  assign bus.trap_kind  = kind_q;
  assign bus.trap_count = count_q;

endmodule
